output_port_alloc: RTL and testbench

//  Wormhole output-port allocator for one router output. N input ports request the

---
 rtl/alloc_pkg.sv | 17 +
 rtl/output_port_alloc_rr_pick.sv | 42 ++++
 rtl/output_port_alloc.sv | 119 +++++++++++
 tb/tb_output_port_alloc.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alloc_pkg.sv
// Shared types and helpers for the wormhole output-port allocator.
package alloc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

  // One-hot of idx within an n-bit field; callers size-cast the result to their width.
  function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned n);
    logic [31:0] v;
    v = '0;
    if (idx < n) v = 32'd1 << idx;
    return v;
  endfunction

endpackage

// File: rtl/output_port_alloc_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  int   w_best_dist;
  int   w_dist;
  int   w_sel;
  logic w_any;

  // Rank each requester by its wrapped distance from the pointer; nearest wins.
  always_comb begin
    w_best_dist = N;
    w_dist      = 0;
    w_sel       = 0;
    w_any       = 1'b0;
    idx_o       = '0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j >= int'(ptr_i)) ? (j - int'(ptr_i)) : (j + N - int'(ptr_i));
      if (req_i[j] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_sel       = j;
        w_any       = 1'b1;
        idx_o       = IW'(j);
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int j = 0; j < N; j++) begin
      grant_o[j] = w_any && (w_sel == j);
    end
  end

endmodule

// File: rtl/output_port_alloc.sv
// Wormhole output-port allocator: round-robin head arbitration, lock until tail.
// Optional stall timeout on the lock is built when OUTPUT_ALLOC_TIMEOUT_EN is defined.
module output_port_alloc
  import alloc_pkg::*;
#(
  parameter int N_REQ   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         head_i,
  input  logic [N_REQ-1:0]         tail_i,
  input  logic                     out_ready_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic                     locked_o,
  output logic [$clog2(N_REQ)-1:0] owner_o,
  output logic                     timeout_o
);

  localparam int IW = $clog2(N_REQ);

  alloc_state_t     r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_owner;

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_rr_grant;
  logic [N_REQ-1:0] w_owner_oh;
  logic [IW-1:0]    w_rr_idx;
  logic [IW-1:0]    w_win_idx;
  logic [IW-1:0]    w_next_ptr;
  logic             w_xfer;
  logic             w_win_tail;
  logic             w_force;

  // Only head flits compete for an unlocked output.
  assign w_elig = req_i & head_i;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i   (w_elig),
    .ptr_i   (r_ptr),
    .grant_o (w_rr_grant),
    .idx_o   (w_rr_idx)
  );

  assign w_owner_oh = N_REQ'(onehot(32'(r_owner), N_REQ));

  // While locked only the owner can move; a low owner request is a bubble.
  always_comb begin
    grant_o = '0;
    if (arst) begin
      grant_o = (r_state == LOCKED) ? (w_owner_oh & req_i) : w_rr_grant;
    end
  end

  assign w_xfer     = (|grant_o) && out_ready_i;
  assign w_win_tail = |(grant_o & tail_i);
  assign w_win_idx  = (r_state == LOCKED) ? r_owner : w_rr_idx;
  assign w_next_ptr = (w_win_idx == IW'(N_REQ - 1)) ? '0 : (w_win_idx + 1'b1);

`ifdef OUTPUT_ALLOC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  assign w_force = (r_state == LOCKED) && !w_xfer && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if ((r_state != LOCKED) || w_xfer || w_force) r_cnt <= '0;
      else                                          r_cnt <= r_cnt + 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_force = 1'b0;
  // The stall limit has no effect unless the timeout logic is built.
  assign timeout_o = 1'b0 & (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_owner <= w_rr_idx;
            if (w_win_tail) r_ptr   <= w_next_ptr;
            else            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          // Release never hands over in the same cycle; the next winner is picked from IDLE.
          if (w_force || (w_xfer && w_win_tail)) begin
            r_state <= IDLE;
            r_ptr   <= w_next_ptr;
          end
        end
      endcase
    end
  end

  assign locked_o = (r_state == LOCKED);
  assign owner_o  = r_owner;

endmodule

// File: tb/tb_output_port_alloc.sv
// Self-checking bench for output_port_alloc with a behavioural allocation model.
module tb_output_port_alloc;

  localparam int N  = 5;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       arst;
  logic [4:0] req_i, head_i, tail_i;
  logic       out_ready_i;
  logic [4:0] grant_o;
  logic       locked_o;
  logic [2:0] owner_o;
  logic       timeout_o;

  int n_pass  = 0;
  int n_total = 0;

  bit m_locked;
  int m_owner, m_ptr, m_cnt;
  bit m_to;

  output_port_alloc #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .arst        (arst),
    .req_i       (req_i),
    .head_i      (head_i),
    .tail_i      (tail_i),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .locked_o    (locked_o),
    .owner_o     (owner_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  // Expected grant from the allocation rules: owner-only when locked, else nearest head at/after ptr.
  function automatic logic [4:0] model_grant();
    logic [4:0] g;
    g = '0;
    if (!arst) return g;
    if (m_locked) begin
      if (req_i[m_owner]) g[m_owner] = 1'b1;
      return g;
    end
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req_i[k] && head_i[k]) begin
        g[k] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic int idx_of(input logic [4:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
  endtask

  task automatic apply(input logic [4:0] r, input logic [4:0] h, input logic [4:0] t, input logic rd);
    req_i = r; head_i = h; tail_i = t; out_ready_i = rd;
    #1;
  endtask

  // Advance model and DUT by one clock, ending on the following falling edge.
  task automatic tick();
    logic [4:0] g;
    bit xfer, n_locked, n_to;
    int w, n_owner, n_ptr, n_cnt;
    g = model_grant();
    xfer = (g != 0) && out_ready_i;
    w = m_locked ? m_owner : idx_of(g);
    n_locked = m_locked; n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt; n_to = 1'b0;
    if (!m_locked) begin
      if (xfer) begin
        n_owner = w;
        if (tail_i[w]) n_ptr = (w + 1) % N;
        else           n_locked = 1'b1;
      end
    end else if (xfer) begin
      n_cnt = 0;
      if (tail_i[w]) begin n_locked = 1'b0; n_ptr = (w + 1) % N; end
    end else begin
`ifdef OUTPUT_ALLOC_TIMEOUT_EN
      if (m_cnt + 1 >= TO) begin
        n_locked = 1'b0; n_ptr = (w + 1) % N; n_cnt = 0; n_to = 1'b1;
      end else n_cnt = m_cnt + 1;
`endif
    end
    @(posedge clk);
    m_locked = n_locked; m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt; m_to = n_to;
    @(negedge clk);
  endtask

  task automatic do_reset();
    arst = 1'b0;
    apply(5'b0, 5'b0, 5'b0, 1'b0);
    @(negedge clk);
    arst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    arst = 1'b0;
    apply(5'($urandom), 5'($urandom), 5'($urandom), 1'b1);
    n_total++; if (grant_o !== 5'b0) $display("FAIL reset grant: got %b want 00000", grant_o); else n_pass++;
    n_total++; if (locked_o !== 1'b0) $display("FAIL reset locked: got %b want 0", locked_o); else n_pass++;
    n_total++; if (owner_o !== 3'd0) $display("FAIL reset owner: got %0d want 0", owner_o); else n_pass++;
    n_total++; if (timeout_o !== 1'b0) $display("FAIL reset timeout: got %b want 0", timeout_o); else n_pass++;
    do_reset();
  endtask

  task automatic test_single_flit();
    logic [4:0] exp_g [3];
    exp_g = '{5'b00100, 5'b10000, 5'b00100};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply(5'b10100, 5'b11111, 5'b11111, 1'b1);
      n_total++; if (grant_o !== exp_g[c]) $display("FAIL single grant c%0d: got %b want %b", c, grant_o, exp_g[c]); else n_pass++;
      tick();
      n_total++; if (locked_o !== 1'b0) $display("FAIL single locked c%0d: got %b want 0", c, locked_o); else n_pass++;
    end
  endtask

  task automatic test_wormhole();
    logic [4:0] r, h, t, eg;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      r = (c < 4) ? 5'b01010 : 5'b01000;
      h = {1'b0, 1'b1, 1'b0, (c == 0), 1'b0};
      t = {1'b0, 1'b1, 1'b0, (c == 3), 1'b0};
      eg = (c < 4) ? 5'b00010 : 5'b01000;
      apply(r, h, t, 1'b1);
      n_total++; if (grant_o !== eg) $display("FAIL worm grant c%0d: got %b want %b", c, grant_o, eg); else n_pass++;
      tick();
      n_total++; if (locked_o !== (c < 3)) $display("FAIL worm locked c%0d: got %b want %b", c, locked_o, (c < 3)); else n_pass++;
      if (c == 0) begin
        n_total++; if (owner_o !== 3'd1) $display("FAIL worm owner: got %0d want 1", owner_o); else n_pass++;
      end
    end
  endtask

  task automatic test_stall_bubble();
    do_reset();
    apply(5'b00001, 5'b00001, 5'b00000, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      apply(5'b00001, 5'b00000, 5'b00000, 1'b0);
      n_total++; if (grant_o !== 5'b00001) $display("FAIL stall grant c%0d: got %b want 00001", c, grant_o); else n_pass++;
      tick();
      n_total++; if (locked_o !== 1'b1) $display("FAIL stall locked c%0d: got %b want 1", c, locked_o); else n_pass++;
    end
    for (int c = 0; c < 2; c++) begin
      apply(5'b00100, 5'b00100, 5'b00100, 1'b1);
      n_total++; if (grant_o !== 5'b00000) $display("FAIL bubble grant c%0d: got %b want 00000", c, grant_o); else n_pass++;
      tick();
      n_total++; if (locked_o !== 1'b1) $display("FAIL bubble locked c%0d: got %b want 1", c, locked_o); else n_pass++;
    end
    apply(5'b00001, 5'b00000, 5'b00001, 1'b1);
    n_total++; if (grant_o !== 5'b00001) $display("FAIL bubble tail grant: got %b want 00001", grant_o); else n_pass++;
    tick();
    n_total++; if (locked_o !== 1'b0) $display("FAIL bubble release: got %b want 0", locked_o); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    apply(5'b00100, 5'b00100, 5'b00000, 1'b1);
    tick();
    apply(5'b00100, 5'b00000, 5'b00000, 1'b1);
    n_total++; if (grant_o !== 5'b00100) $display("FAIL midrst body grant: got %b want 00100", grant_o); else n_pass++;
    arst = 1'b0;
    #1;
    n_total++; if (locked_o !== 1'b0) $display("FAIL midrst locked: got %b want 0", locked_o); else n_pass++;
    n_total++; if (grant_o !== 5'b00000) $display("FAIL midrst grant: got %b want 00000", grant_o); else n_pass++;
    @(negedge clk);
    arst = 1'b1;
    model_reset();
    apply(5'b01010, 5'b01010, 5'b01010, 1'b1);
    n_total++; if (grant_o !== 5'b00010) $display("FAIL midrst restart grant: got %b want 00010", grant_o); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    logic [4:0] eg;
    do_reset();
    apply(5'b00100, 5'b00100, 5'b00000, 1'b1);
    tick();
    for (int c = 0; c < TO; c++) begin
      apply(5'b01000, 5'b01000, 5'b01000, 1'b1);
      eg = model_grant();
      n_total++; if (grant_o !== eg) $display("FAIL tmo grant c%0d: got %b want %b", c, grant_o, eg); else n_pass++;
      tick();
      n_total++; if (locked_o !== m_locked) $display("FAIL tmo locked c%0d: got %b want %b", c, locked_o, m_locked); else n_pass++;
      n_total++; if (timeout_o !== m_to) $display("FAIL tmo pulse c%0d: got %b want %b", c, timeout_o, m_to); else n_pass++;
    end
    apply(5'b01000, 5'b01000, 5'b01000, 1'b1);
    eg = model_grant();
    n_total++; if (grant_o !== eg) $display("FAIL tmo next grant: got %b want %b", grant_o, eg); else n_pass++;
    tick();
    n_total++; if (timeout_o !== 1'b0) $display("FAIL tmo pulse width: got %b want 0", timeout_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      logic [4:0] eg;
      eg = 5'd1 << (c % N);
      apply(5'b11111, 5'b11111, 5'b11111, 1'b1);
      n_total++; if (grant_o !== eg) $display("FAIL b2b grant c%0d: got %b want %b", c, grant_o, eg); else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    logic [4:0] eg;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      apply(5'($urandom), 5'($urandom), 5'($urandom), ($urandom_range(0, 3) != 0));
      eg = model_grant();
      n_total++; if (grant_o !== eg) $display("FAIL rand grant c%0d: got %b want %b", c, grant_o, eg); else n_pass++;
      tick();
      n_total++; if (locked_o !== m_locked) $display("FAIL rand locked c%0d: got %b want %b", c, locked_o, m_locked); else n_pass++;
      n_total++; if (owner_o !== 3'(m_owner)) $display("FAIL rand owner c%0d: got %0d want %0d", c, owner_o, m_owner); else n_pass++;
      n_total++; if (timeout_o !== m_to) $display("FAIL rand timeout c%0d: got %b want %b", c, timeout_o, m_to); else n_pass++;
    end
  endtask

  initial begin
    arst = 1'b0;
    req_i = '0; head_i = '0; tail_i = '0; out_ready_i = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_flit();
    test_wormhole();
    test_stall_bubble();
    test_reset_mid_packet();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
